// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU control sequencer: state encoding,
// opcodes, ARM-style condition codes and NZCV flag bit positions.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_WAIT   = 4'd2,
        ST_DECODE = 4'd3,
        ST_EXEC   = 4'd4,
        ST_MEM    = 4'd5,
        ST_WB     = 4'd6,
        ST_NEXT   = 4'd7,
`ifdef CPU_SINGLE_STEP_EN
        ST_STALL  = 4'd9,
`endif
        ST_HALT   = 4'd8
    } state_t;

    localparam logic [3:0] OPC_CMP  = 4'hA;
    localparam logic [3:0] OPC_LDR  = 4'hC;
    localparam logic [3:0] OPC_STR  = 4'hD;
    localparam logic [3:0] OPC_HALT = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cpu_cond_check.sv
// Combinational ARM-style condition evaluation: decides whether an instruction
// with the given condition field executes under the current NZCV flags.
module cpu_cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flag,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flag[FLAG_N];
    assign z = flag[FLAG_Z];
    assign c = flag[FLAG_C];
    assign v = flag[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer owning the pc, flags and the shared RAM port.
// Optional CPU_SINGLE_STEP_EN adds a Step input and a STALL state between instructions.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int          RAM_LAT  = 1,
    parameter int          PC_W     = 8,
    parameter logic [3:0]  OP_CMP   = OPC_CMP,
    parameter logic [3:0]  OP_LDR   = OPC_LDR,
    parameter logic [3:0]  OP_STR   = OPC_STR,
    parameter logic [3:0]  OP_HALT  = OPC_HALT
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
`ifdef CPU_SINGLE_STEP_EN
    input  logic            Step,
`endif
    output logic            Enable,
    output logic            RW,
    output logic [15:0]     Address,
    input  logic [31:0]     Out,
    output logic [31:0]     In,
    input  logic [31:0]     Result_2,
    output logic [3:0]      destination,
    output logic [3:0]      source_1,
    output logic [3:0]      source_2,
    output logic            Reg_Write,
    output logic [31:0]     Reg_Wdata,
    output logic [3:0]      OpCode,
    output logic            S,
    output logic [4:0]      IV,
    input  logic [31:0]     Result,
    input  logic [3:0]      New_Flag,
    output logic [3:0]      Flag,
    output logic [PC_W-1:0] pc,
    output logic            Busy,
    output logic            Halted
);

    state_t            state;
    logic [31:0]       instr;
    logic [2:0]        cnt;
    logic [PC_W-1:0]   pc_inc;
    logic              cond_pass;
    logic              unused_instr_bits;

    localparam logic [2:0] LAT = 3'(RAM_LAT);

    assign OpCode      = instr[27:24];
    assign S           = instr[23];
    assign destination = instr[22:19];
    assign source_2    = instr[18:15];
    assign source_1    = instr[14:11];
    assign IV          = instr[10:6];
    assign unused_instr_bits = ^instr[5:0];

    assign pc_inc = pc + 1'b1;

    cpu_cond_check u_cond (
        .cond (instr[31:28]),
        .flag (Flag),
        .pass (cond_pass)
    );

    // Outputs are registered: each transition sets the values the next state presents.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            Flag      <= '0;
            instr     <= '0;
            cnt       <= '0;
            Enable    <= 1'b0;
            RW        <= 1'b0;
            Address   <= '0;
            In        <= '0;
            Reg_Write <= 1'b0;
            Reg_Wdata <= '0;
            Busy      <= 1'b0;
            Halted    <= 1'b0;
        end else begin
            Reg_Write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state   <= ST_FETCH;
                        Enable  <= 1'b1;
                        RW      <= 1'b0;
                        Address <= 16'(pc);
                        Busy    <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    Enable <= 1'b0;
                    cnt    <= 3'd1;
                    state  <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (cnt == LAT) begin
                        instr <= Out;
                        state <= ST_DECODE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end

                ST_DECODE: state <= ST_EXEC;

                ST_EXEC: begin
                    In <= Result_2;
                    if (!cond_pass) begin
                        state <= ST_NEXT;
                    end else if (OpCode == OP_HALT) begin
                        state  <= ST_HALT;
                        Busy   <= 1'b0;
                        Halted <= 1'b1;
                    end else if (OpCode == OP_LDR || OpCode == OP_STR) begin
                        state   <= ST_MEM;
                        cnt     <= 3'd0;
                        Enable  <= 1'b1;
                        RW      <= (OpCode == OP_STR);
                        Address <= Result[15:0];
                    end else begin
                        state     <= ST_WB;
                        Reg_Write <= (OpCode != OP_CMP);
                        Reg_Wdata <= Result;
                    end
                end

                // The access is issued only in the first MEM cycle; the rest waits for data.
                ST_MEM: begin
                    Enable <= 1'b0;
                    RW     <= 1'b0;
                    if (OpCode == OP_STR) begin
                        if (cnt == 3'd1) state <= ST_WB;
                        else             cnt   <= cnt + 3'd1;
                    end else begin
                        if (cnt == LAT) begin
                            Reg_Wdata <= Out;
                            Reg_Write <= 1'b1;
                            state     <= ST_WB;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end

                ST_WB: begin
                    pc <= pc_inc;
                    if (S || OpCode == OP_CMP) Flag <= New_Flag;
`ifdef CPU_SINGLE_STEP_EN
                    state <= ST_STALL;
                    Busy  <= 1'b0;
`else
                    state   <= ST_FETCH;
                    Enable  <= 1'b1;
                    Address <= 16'(pc_inc);
`endif
                end

                ST_NEXT: begin
                    pc <= pc_inc;
`ifdef CPU_SINGLE_STEP_EN
                    state <= ST_STALL;
                    Busy  <= 1'b0;
`else
                    state   <= ST_FETCH;
                    Enable  <= 1'b1;
                    Address <= 16'(pc_inc);
`endif
                end

`ifdef CPU_SINGLE_STEP_EN
                ST_STALL: begin
                    if (Step) begin
                        state   <= ST_FETCH;
                        Enable  <= 1'b1;
                        Address <= 16'(pc);
                        Busy    <= 1'b1;
                    end
                end
`endif

                ST_HALT: state <= ST_HALT;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
